// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file writeback types and constants for the EX/MEM write-port arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned REG_W        = 32;
    localparam int unsigned STARVE_CNT_W = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_word_t;

    localparam reg_addr_t ZERO_REG_ADDR = '0;
    localparam reg_word_t ZERO_WORD     = '0;
    localparam logic      ENABLE        = 1'b1;
    localparam logic      DISABLE       = 1'b0;

    // Which held slot entered first when both are valid.
    typedef enum logic {
        AGE_MEM_OLDER = 1'b0,
        AGE_EX_OLDER  = 1'b1
    } age_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_hold_slot.sv
// One-entry writeback holding slot: accepts on valid/ready, drains on grant, drops x0 writes.
module wb_hold_slot
    import regfile_wb_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      in_valid,
    output logic      in_ready,
    input  reg_addr_t in_addr,
    input  reg_word_t in_data,
    input  logic      grant,
    output logic      valid,
    output reg_addr_t addr,
    output reg_word_t data,
    output logic      fill
);

    assign in_ready = rdy && !rst && (!valid || grant);
    // x0 writes complete the handshake but never occupy the slot.
    assign fill     = in_valid && in_ready && (in_addr != ZERO_REG_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= DISABLE;
            addr  <= ZERO_REG_ADDR;
            data  <= ZERO_WORD;
        end else if (fill) begin
            valid <= ENABLE;
            addr  <= in_addr;
            data  <= in_data;
        end else if (rdy && grant) begin
            valid <= DISABLE;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the EX and MEM writeback paths,
// keeping same-register program order and bounding EX starvation.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CNT_W        = STARVE_CNT_W
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      ex_valid,
    output logic      ex_ready,
    input  reg_addr_t ex_addr,
    input  reg_word_t ex_data,
    input  logic      mem_valid,
    output logic      mem_ready,
    input  reg_addr_t mem_addr,
    input  reg_word_t mem_data,
    output logic      w_enable,
    output reg_addr_t w_addr,
    output reg_word_t w_data,
    output logic      busy
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             ex_v, mem_v, ex_fill, mem_fill, ex_gnt, mem_gnt;
    reg_addr_t        ex_a, mem_a;
    reg_word_t        ex_d, mem_d;
    logic [CNT_W-1:0] starve_cnt;
    age_t             age;

    wb_hold_slot u_ex_slot (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .in_valid (ex_valid),
        .in_ready (ex_ready),
        .in_addr  (ex_addr),
        .in_data  (ex_data),
        .grant    (ex_gnt),
        .valid    (ex_v),
        .addr     (ex_a),
        .data     (ex_d),
        .fill     (ex_fill)
    );

    wb_hold_slot u_mem_slot (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .in_valid (mem_valid),
        .in_ready (mem_ready),
        .in_addr  (mem_addr),
        .in_data  (mem_data),
        .grant    (mem_gnt),
        .valid    (mem_v),
        .addr     (mem_a),
        .data     (mem_d),
        .fill     (mem_fill)
    );

    // Grant looks only at held entries so the request inputs never race the write port.
    always_comb begin
        ex_gnt  = DISABLE;
        mem_gnt = DISABLE;
        if (ex_v && !mem_v) begin
            ex_gnt = ENABLE;
        end else if (mem_v && !ex_v) begin
            mem_gnt = ENABLE;
        end else if (ex_v && mem_v) begin
            if (ex_a == mem_a) begin
                if (age == AGE_EX_OLDER) ex_gnt = ENABLE;
                else                     mem_gnt = ENABLE;
            end else if (starve_cnt == LIMIT) begin
                ex_gnt = ENABLE;
            end else begin
                mem_gnt = ENABLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_enable   <= DISABLE;
            w_addr     <= ZERO_REG_ADDR;
            w_data     <= ZERO_WORD;
            starve_cnt <= '0;
            age        <= AGE_MEM_OLDER;
        end else if (rdy) begin
            w_enable <= ex_gnt || mem_gnt;
            if (ex_gnt) begin
                w_addr <= ex_a;
                w_data <= ex_d;
            end else if (mem_gnt) begin
                w_addr <= mem_a;
                w_data <= mem_d;
            end

            if (ex_v && mem_gnt)
                starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;

            // A simultaneous fill makes MEM older: the load precedes EX in program order.
            if (ex_fill && (mem_fill || (mem_v && !mem_gnt)))
                age <= AGE_MEM_OLDER;
            else if (mem_fill && ex_v && !ex_gnt)
                age <= AGE_EX_OLDER;
        end
    end

    assign busy = ex_v || mem_v || w_enable;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed checks of regfile_wb_arbiter against a sequence-stamped behavioural model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int LIMIT = 3;

    logic      clk = 1'b0;
    logic      rst = 1'b1, rdy = 1'b1;
    logic      ex_valid = 1'b0, mem_valid = 1'b0;
    reg_addr_t ex_addr = '0, mem_addr = '0;
    reg_word_t ex_data = '0, mem_data = '0;
    logic      ex_ready, mem_ready, w_enable, busy;
    reg_addr_t w_addr;
    reg_word_t w_data;

    int checks = 0;
    int errors = 0;

    // Model: index 0 = EX, 1 = MEM; each held entry carries an arrival stamp.
    bit        m_v[2];
    int        m_a[2];
    reg_word_t m_d[2];
    int        m_stamp[2];
    int        stamp_ctr = 0;
    int        m_loss = 0;
    bit        m_wen = 1'b0;
    int        m_wa = 0;
    reg_word_t m_wd = '0;
    reg_word_t dut_rf[32];

    logic      s_we;
    reg_addr_t s_wa;
    reg_word_t s_wd;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_addr   (ex_addr),
        .ex_data   (ex_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .w_enable  (w_enable),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_v[0] && !m_v[1]) return 0;
        if (m_v[1] && !m_v[0]) return 1;
        if (!m_v[0] && !m_v[1]) return -1;
        if (m_a[0] == m_a[1]) return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
        return (m_loss == LIMIT) ? 0 : 1;
    endfunction

    function automatic bit model_ready(input int idx, input int g);
        return rdy && !rst && (!m_v[idx] || g == idx);
    endfunction

    task automatic model_reset();
        m_v[0] = 1'b0; m_v[1] = 1'b0;
        m_loss = 0; m_wen = 1'b0; m_wa = 0; m_wd = '0;
    endtask

    task automatic compare();
        int g;
        g = model_grant();
        chk("ex_ready",  32'(ex_ready),  32'(model_ready(0, g)));
        chk("mem_ready", 32'(mem_ready), 32'(model_ready(1, g)));
        chk("w_enable",  32'(w_enable),  32'(m_wen));
        chk("w_addr",    32'(w_addr),    32'(m_wa));
        chk("w_data",    w_data,         m_wd);
        chk("busy",      32'(busy),      32'(m_v[0] | m_v[1] | m_wen));
    endtask

    task automatic model_update();
        int g;
        bit er, mr;
        g  = model_grant();
        er = model_ready(0, g);
        mr = model_ready(1, g);
        if (rst) begin
            model_reset();
        end else if (rdy) begin
            m_wen = (g >= 0);
            if (g >= 0) begin
                m_wa = m_a[g];
                m_wd = m_d[g];
            end
            if (m_v[0] && g == 1) m_loss = (m_loss < LIMIT) ? m_loss + 1 : m_loss;
            else                  m_loss = 0;
            if (g >= 0) m_v[g] = 1'b0;
            if (mr && mem_valid && mem_addr != 0) begin
                m_v[1] = 1'b1; m_a[1] = int'(mem_addr); m_d[1] = mem_data;
                m_stamp[1] = stamp_ctr++;
            end
            if (er && ex_valid && ex_addr != 0) begin
                m_v[0] = 1'b1; m_a[0] = int'(ex_addr); m_d[0] = ex_data;
                m_stamp[0] = stamp_ctr++;
            end
        end
    endtask

    task automatic step(input bit r, input bit y, input bit ev, input int ea, input reg_word_t ed,
                        input bit mv, input int ma, input reg_word_t md);
        @(negedge clk);
        rst = r; rdy = y;
        ex_valid = ev;  ex_addr = 5'(ea);  ex_data = ed;
        mem_valid = mv; mem_addr = 5'(ma); mem_data = md;
        #1;
        compare();
        s_we = w_enable; s_wa = w_addr; s_wd = w_data;
        @(posedge clk);
        if (y && s_we === 1'b1) dut_rf[s_wa] = s_wd;
        model_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, 0, 0, '0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;
        model_reset();
        step(1, 1, 0, 0, '0, 0, 0, '0);
        step(1, 1, 0, 0, '0, 0, 0, '0);

        // Reset with both slots loaded discards them.
        step(0, 1, 1, 3, 32'h33, 1, 5, 32'h55);
        step(1, 1, 0, 0, '0, 0, 0, '0);
        #1;
        chk("rst_wen", 32'(w_enable), 32'h0);
        chk("rst_waddr", 32'(w_addr), 32'h0);
        chk("rst_wdata", w_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        idle(3);
        chk("rst_no_x3", dut_rf[3], 32'h0);
        chk("rst_no_x5", dut_rf[5], 32'h0);

        // EX alone.
        step(0, 1, 1, 5, 32'h0000_00AA, 0, 0, '0);
        #1 chk("ex5_held_busy", 32'(busy), 32'h1);
        idle(1);
        #1;
        chk("ex5_wen", 32'(w_enable), 32'h1);
        chk("ex5_waddr", 32'(w_addr), 32'h5);
        chk("ex5_wdata", w_data, 32'hAA);
        idle(1);
        #1;
        chk("ex5_wen_drop", 32'(w_enable), 32'h0);
        chk("ex5_busy_drop", 32'(busy), 32'h0);

        // Simultaneous fill: MEM first.
        step(0, 1, 1, 6, 32'h1, 1, 7, 32'h2);
        idle(1);
        #1 chk("both_first_addr", 32'(w_addr), 32'h7);
        idle(1);
        #1 chk("both_second_addr", 32'(w_addr), 32'h6);
        idle(2);

        // Sustained traffic from both sides: no idle write cycles.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 16 + i, 32'(i), 1, 24 + (i % 4), 32'(100 + i));
            if (i > 0) #1 chk("b2b_wen", 32'(w_enable), 32'h1);
        end
        idle(4);

        // Same-register order MEM then EX.
        step(0, 1, 0, 0, '0, 1, 9, 32'h11);
        step(0, 1, 1, 9, 32'h22, 0, 0, '0);
        #1 chk("x9_first", w_data, 32'h11);
        idle(1);
        #1 chk("x9_second", w_data, 32'h22);
        idle(2);
        chk("x9_final", dut_rf[9], 32'h22);

        // Starvation: EX held against continuous MEM traffic.
        step(0, 1, 1, 4, 32'h44, 1, 8, 32'h80);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, '0, 1, 8, 32'(32'h81 + i));
            #1 chk("starve_mem_win", 32'(w_addr), 32'h8);
        end
        step(0, 1, 0, 0, '0, 1, 8, 32'h8F);
        #1 chk("starve_ex_win", 32'(w_addr), 32'h4);
        step(0, 1, 1, 4, 32'h45, 1, 8, 32'h90);
        #1 chk("starve_after_a", 32'(w_addr), 32'h8);
        step(0, 1, 0, 0, '0, 1, 8, 32'h91);
        #1 chk("starve_cleared", 32'(w_addr), 32'h8);
        idle(4);

        // x0 write is accepted and dropped.
        step(0, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, '0);
        #1 chk("x0_busy", 32'(busy), 32'h0);
        idle(1);
        #1 chk("x0_wen", 32'(w_enable), 32'h0);

        // rdy=0 freeze with both slots full.
        step(0, 1, 1, 12, 32'hC, 1, 13, 32'hD);
        step(0, 1, 0, 0, '0, 1, 14, 32'hE);
        #1 chk("frz_pre_addr", 32'(w_addr), 32'hD);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 20, 32'h20, 1, 21, 32'h21);
            #1;
            chk("frz_wen", 32'(w_enable), 32'h1);
            chk("frz_addr", 32'(w_addr), 32'hD);
            chk("frz_ex_ready", 32'(ex_ready), 32'h0);
            chk("frz_mem_ready", 32'(mem_ready), 32'h0);
        end
        idle(1);
        #1 chk("frz_after_1", 32'(w_addr), 32'hE);
        idle(1);
        #1 chk("frz_after_2", 32'(w_addr), 32'hC);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)), reg_word_t'($urandom),
                 ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)), reg_word_t'($urandom));
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between the two writeback requesters, the EX result path and the MEM (load) result path. Each requester gets a one-entry holding slot with a valid/ready handshake. A registered arbiter drives w_enable/w_addr/w_data into the register file. It preserves program order for same-register writes and bounds EX starvation.

Parameters:
STARVE_LIMIT, 3, number of consecutive cycles a held EX entry may lose to MEM before EX is forced to win.
CNT_W, 2, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
rdy  input  1  global ready; 0 freezes the block
ex_valid  input  1  EX offers a write
ex_ready  output  1  EX slot can accept
ex_addr  input  RegAddrBus  EX destination register
ex_data  input  RegBus  EX result
mem_valid  input  1  MEM offers a write
mem_ready  output  1  MEM slot can accept
mem_addr  input  RegAddrBus  MEM destination register
mem_data  input  RegBus  MEM result
w_enable  output  1  to register-file write enable (registered)
w_addr  output  RegAddrBus  to register-file write address (registered)
w_data  output  RegBus  to register-file write data (registered)
busy  output  1  any slot valid or w_enable high

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high; rdy is the global ready.
- Reset:
  - Both slots invalid; w_enable=0, w_addr=ZeroRegAddr, w_data=ZeroWord.
  - Starvation counter=0, age bit=0.
  - ex_ready and mem_ready are forced to 0 while rst=1.
  - Reset mid-operation discards held entries with no write issued.
- Accept:
  - A request is accepted at a posedge where valid && ready && rdy && !rst.
  - ready = rdy && !rst && (!slot_valid || slot_granted_this_cycle). A slot can drain and refill in the same cycle.
- x0 writes: accepted but never stored, and do not consume the port.
- Grant is combinational and computed from the slot registers only, never from the *_valid inputs. Priority order:
  1. Only one slot valid: that slot wins.
  2. Both valid with the same address: the older slot (per the age bit) wins.
  3. Starvation counter == STARVE_LIMIT: EX wins.
  4. Otherwise MEM wins.
- Age bit:
  - Records which slot is older when both are valid.
  - A slot filled while the other is valid is younger.
  - If both are filled on the same edge, MEM is older, because the MEM instruction precedes EX in program order.
- Output register:
  - At each posedge with rdy=1, w_* load the granted entry and w_enable=1; if nothing is granted, w_enable=0.
  - Latency: accepted at edge k, earliest w_enable=1 after edge k+1, committed in the register file at edge k+2.
- Starvation counter:
  - Increments when the EX slot is valid and MEM is granted, saturating at STARVE_LIMIT.
  - Clears when EX is granted or the EX slot is empty.
- rdy=0: all state and outputs hold, and both ready outputs are 0. The register file ignores w_enable while rdy=0, so a held w_enable=1 is harmless.
- Throughput: one write per cycle sustained; no bubble when a slot drains and refills.

Decomposition:
- Use the shared config.v macros RegAddrBus, RegBus, Enable, Disable, ZeroWord and ZeroRegAddr.
- Add StarveCntBus to config.v.
- One sub-module, wb_hold_slot: a one-entry valid/addr/data buffer with accept, drain and x0-drop logic. It is instantiated twice (EX, MEM).

Test Plan:
- Reset with both slots loaded -> after rst, w_enable=0, w_addr=0, w_data=0; no write to x3 or x5 occurs.
- EX alone writes x5=0x0000_00AA for one cycle -> ex_ready=1; w_enable=1, w_addr=5, w_data=0xAA exactly one cycle after acceptance; busy falls after it.
- Both valid on the same edge, EX x6=1 and MEM x7=2 -> x7 issued first, then x6. Sustained back-to-back EX and MEM traffic shows no idle cycles on w_enable.
- MEM x9=0x11 accepted, then EX x9=0x22 the next cycle -> w_data order 0x11 then 0x22; the final register-file x9 read is 0x22.
- MEM valid every cycle with EX held (STARVE_LIMIT=3) -> EX is granted on the 4th contended cycle; the counter then returns to 0.
- EX writes x0=0xFFFF_FFFF -> accepted, w_enable stays 0. Holding rdy=0 for 5 cycles with both slots full -> outputs frozen, ready=0, and order is unchanged after rdy returns to 1.
